// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
// Byte helpers follow the core's {b0,b1,b2,b3} word packing (b0 in the MSBs).
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_MISS = 2'd1,
    WR_THRU = 2'd2
  } state_e;

  localparam int DC_INDEX_BITS = 6;
  localparam int TAG_W         = 32 - DC_INDEX_BITS - 2;
  localparam int LINE_CNT      = 1 << DC_INDEX_BITS;

  localparam int BYTE0_LSB = 24;
  localparam int BYTE1_LSB = 16;
  localparam int BYTE2_LSB = 8;
  localparam int BYTE3_LSB = 0;

  function automatic logic [31:0] pack_bytes(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3);
    return {b0, b1, b2, b3};
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage: asynchronous read, synchronous write, valid bits
// cleared by async reset or a synchronous clear (clear wins over a same-edge write).
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] rd_index,
  input  logic [TAG_BITS-1:0]   rd_tag,
  output logic                  rd_hit,
  output logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [31:0]           wr_data,
  input  logic                  clr
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

  assign rd_hit  = valid_q[rd_index] && (tag_q[rd_index] == rd_tag);
  assign rd_data = data_q[rd_index];

endmodule

// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache for the single-cycle core.
// Hits complete in the same cycle; load misses and all stores stall on a req/ack memory transaction.
module dcache_dm_wt
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [31:0]      core_addr,
  input  logic             core_rd_en,
  input  logic             core_wr_en,
  input  logic [31:0]      core_wdata,
  output logic [31:0]      core_rdata,
  output logic             core_stall,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int TAG_BITS = 32 - INDEX_BITS - 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e             state_q;
  logic               mem_req_q, mem_we_q;
  logic [31:0]        mem_addr_q, mem_wdata_q, fill_q;
  logic               done_q, done_rd_q, flush_pend_q;
  logic [CNT_W-1:0]   hit_q, miss_q;

  logic [31:0]         lk_addr;
  logic [INDEX_BITS-1:0] lk_index;
  logic [TAG_BITS-1:0] lk_tag;
  logic                line_hit;
  logic [31:0]         line_data;
  logic                idle, st_req, ld_req, ld_hit, ld_miss, ack;
  logic                arr_we, arr_clr;
  logic [31:0]         arr_wdata;
  logic                unused_addr_bits;

  // While a transaction is in flight, look up the latched address, not the core's.
  assign lk_addr  = (state_q == IDLE) ? core_addr : mem_addr_q;
  assign lk_index = lk_addr[INDEX_BITS+1:2];
  assign lk_tag   = lk_addr[31:INDEX_BITS+2];
  assign unused_addr_bits = ^lk_addr[1:0];

  // done_q marks the one cycle after ack, where the held request is already complete.
  assign idle    = (state_q == IDLE);
  assign st_req  = idle && !done_q && core_wr_en;
  assign ld_req  = idle && !done_q && core_rd_en && !core_wr_en;
  assign ld_hit  = ld_req && line_hit;
  assign ld_miss = ld_req && !line_hit;
  assign ack     = mem_req_q && mem_ack;

  assign arr_we    = ack && ((state_q == RD_MISS) || ((state_q == WR_THRU) && line_hit));
  assign arr_wdata = (state_q == RD_MISS) ? mem_rdata : mem_wdata_q;
  assign arr_clr   = (idle && flush) || (ack && (flush_pend_q || flush));

  assign core_stall = !idle || st_req || ld_miss;
  assign core_rdata = (idle && done_q && done_rd_q) ? fill_q :
                      ld_hit                        ? line_data : 32'h0;

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  dcache_line_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_lines (
    .clk      (clk),
    .rst_b    (rst_b),
    .rd_index (lk_index),
    .rd_tag   (lk_tag),
    .rd_hit   (line_hit),
    .rd_data  (line_data),
    .wr_en    (arr_we),
    .wr_index (lk_index),
    .wr_tag   (lk_tag),
    .wr_data  (arr_wdata),
    .clr      (arr_clr)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      fill_q       <= 32'h0;
      done_q       <= 1'b0;
      done_rd_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      hit_q        <= '0;
      miss_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          flush_pend_q <= 1'b0;
          if (st_req) begin
            mem_addr_q  <= {lk_addr[31:2], 2'b00};
            mem_wdata_q <= core_wdata;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            state_q     <= WR_THRU;
          end else if (ld_miss) begin
            mem_addr_q <= {lk_addr[31:2], 2'b00};
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            state_q    <= RD_MISS;
            if (!(&miss_q)) miss_q <= miss_q + CNT_ONE;
          end else if (ld_hit) begin
            if (!(&hit_q)) hit_q <= hit_q + CNT_ONE;
          end
        end
        RD_MISS, WR_THRU: begin
          if (flush) flush_pend_q <= 1'b1;
          if (ack) begin
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b1;
            done_rd_q    <= (state_q == RD_MISS);
            flush_pend_q <= 1'b0;
            state_q      <= IDLE;
            if (state_q == RD_MISS) fill_q <= mem_rdata;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Self-checking bench: directed plan steps plus random loads/stores/flushes against
// an abstract cache + memory model; a CNT_W=2 twin on the same inputs checks saturation.
module tb_dcache_dm_wt;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0, mem_rdata = '0;
  logic        core_rd_en = 1'b0, core_wr_en = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [31:0] core_rdata, mem_addr, mem_wdata;
  logic        core_stall, mem_req, mem_we;
  logic [31:0] hit_count, miss_count;
  logic [31:0] rdata2, addr2, wdata2;
  logic        stall2, req2, we2;
  logic [1:0]  hc2, mc2;

  always #5 clk = ~clk;

  dcache_dm_wt #(.INDEX_BITS(6), .CNT_W(32)) u_dut (
    .clk(clk), .rst_b(rst_b), .core_addr(core_addr), .core_rd_en(core_rd_en),
    .core_wr_en(core_wr_en), .core_wdata(core_wdata), .core_rdata(core_rdata),
    .core_stall(core_stall), .flush(flush), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count));

  dcache_dm_wt #(.INDEX_BITS(6), .CNT_W(2)) u_sat (
    .clk(clk), .rst_b(rst_b), .core_addr(core_addr), .core_rd_en(core_rd_en),
    .core_wr_en(core_wr_en), .core_wdata(core_wdata), .core_rdata(rdata2),
    .core_stall(stall2), .flush(flush), .mem_req(req2), .mem_we(we2),
    .mem_addr(addr2), .mem_wdata(wdata2), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hc2), .miss_count(mc2));

  // Reference model: line contents, backing memory keyed by word address, event counts.
  bit          valid_m [64];
  logic [23:0] tag_m   [64];
  logic [31:0] data_m  [64];
  logic [31:0] mem_m   [logic [29:0]];
  int          hits_m = 0, misses_m = 0;
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat3(input int x);
    return (x > 3) ? 32'd3 : 32'(x);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) valid_m[i] = 1'b0;
  endtask

  task automatic chk_counts();
    chk("hit_count", hit_count, 32'(hits_m));
    chk("miss_count", miss_count, 32'(misses_m));
    chk("hit_sat2", 32'(hc2), sat3(hits_m));
    chk("miss_sat2", 32'(mc2), sat3(misses_m));
  endtask

  // Memory side of one transaction: ack after lat wait cycles, optional flush at wait cycle flush_c.
  task automatic txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int lat, input int flush_c, output logic [31:0] rd_out);
    logic [29:0] wa;
    wa = addr[31:2];
    rd_out = '0;
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      flush = (c == flush_c);
      #1;
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(is_wr));
      chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
      chk("stall_busy", 32'(core_stall), 32'd1);
      if (is_wr) chk("mem_wdata", mem_wdata, wdata);
      if (c == lat) begin
        mem_ack = 1'b1;
        if (is_wr) mem_rdata = $urandom;
        else begin
          if (!mem_m.exists(wa)) mem_m[wa] = $urandom;
          mem_rdata = mem_m[wa];
          rd_out = mem_m[wa];
        end
      end
      @(posedge clk);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    flush = 1'b0;
    if (is_wr) mem_m[wa] = wdata;
  endtask

  task automatic do_load(input logic [31:0] addr, input int lat, input int flush_c,
                         input bit flush_now);
    int idx;
    logic [23:0] tg;
    logic [31:0] word;
    bit exp_hit;
    idx = int'(addr[7:2]);
    tg = addr[31:8];
    exp_hit = valid_m[idx] && (tag_m[idx] == tg);
    @(negedge clk);
    core_addr = addr | 32'($urandom_range(0, 3));
    core_rd_en = 1'b1;
    core_wr_en = 1'b0;
    flush = flush_now;
    #1;
    if (exp_hit) begin
      chk("hit_stall", 32'(core_stall), 32'd0);
      chk("hit_rdata", core_rdata, data_m[idx]);
      chk("hit_no_req", 32'(mem_req), 32'd0);
      @(posedge clk);
      hits_m++;
      if (flush_now) model_clear();
    end else begin
      chk("miss_stall", 32'(core_stall), 32'd1);
      @(posedge clk);
      misses_m++;
      if (flush_now) model_clear();
      txn(1'b0, addr, 32'h0, lat, flush_c, word);
      valid_m[idx] = 1'b1;
      tag_m[idx] = tg;
      data_m[idx] = word;
      if (flush_c >= 0 && flush_c <= lat) model_clear();
      #1;
      chk("fill_stall", 32'(core_stall), 32'd0);
      chk("fill_rdata", core_rdata, word);
      chk("fill_req_low", 32'(mem_req), 32'd0);
      @(posedge clk);
    end
    @(negedge clk);
    core_rd_en = 1'b0;
    flush = 1'b0;
    #1;
    chk_counts();
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] wdata, input bit also_rd,
                          input int lat, input int flush_c);
    int idx;
    logic [31:0] dummy;
    bit exp_hit;
    idx = int'(addr[7:2]);
    exp_hit = valid_m[idx] && (tag_m[idx] == addr[31:8]);
    @(negedge clk);
    core_addr = addr | 32'($urandom_range(0, 3));
    core_wdata = wdata;
    core_wr_en = 1'b1;
    core_rd_en = also_rd;
    #1;
    chk("st_stall", 32'(core_stall), 32'd1);
    @(posedge clk);
    txn(1'b1, addr, wdata, lat, flush_c, dummy);
    if (exp_hit) data_m[idx] = wdata;
    if (flush_c >= 0 && flush_c <= lat) model_clear();
    #1;
    chk("st_done_stall", 32'(core_stall), 32'd0);
    chk("st_req_low", 32'(mem_req), 32'd0);
    @(posedge clk);
    @(negedge clk);
    core_wr_en = 1'b0;
    core_rd_en = 1'b0;
    #1;
    chk_counts();
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall", 32'(core_stall), 32'd0);
    chk("flush_no_req", 32'(mem_req), 32'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_rdata", core_rdata, 32'h0);
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk_counts();
    @(negedge clk);
    rst_b = 1'b1;

    // Plan 1-2: cold miss, hit, conflicting-tag replacement.
    mem_m[30'h40] = 32'hDEADBEEF;
    do_load(32'h0000_0100, 3, -1, 1'b0);
    chk("p1_miss_count", miss_count, 32'd1);
    do_load(32'h0000_0100, 0, -1, 1'b0);
    chk("p2_hit_count", hit_count, 32'd1);
    do_load(32'h0000_4100, 1, -1, 1'b0);
    do_load(32'h0000_4100, 0, -1, 1'b0);

    // Plan 3: store hit updates the line; store miss writes memory only.
    do_load(32'h0000_0100, 2, -1, 1'b0);
    do_store(32'h0000_0100, 32'h12345678, 1'b0, 2, -1);
    do_load(32'h0000_0100, 0, -1, 1'b0);
    do_store(32'h0000_0200, 32'hCAFEF00D, 1'b1, 1, -1);
    do_load(32'h0000_0200, 2, -1, 1'b0);
    chk("p3_mem_written", mem_m[30'h80], 32'hCAFEF00D);

    // Plan 4: flush during RD_MISS invalidates the filled line too.
    do_load(32'h0000_0304, 3, 1, 1'b0);
    do_load(32'h0000_0304, 1, -1, 1'b0);
    do_load(32'h0000_0304, 0, -1, 1'b1);
    do_load(32'h0000_0304, 0, -1, 1'b0);

    // Plan 5: reset two cycles into a miss; a late ack must be ignored.
    @(negedge clk);
    core_addr = 32'h0000_7700;
    core_rd_en = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b0;
    core_rd_en = 1'b0;
    #1;
    chk("r5_req_drop", 32'(mem_req), 32'd0);
    hits_m = 0;
    misses_m = 0;
    model_clear();
    chk_counts();
    @(negedge clk);
    rst_b = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBADBAD00;
    #1;
    chk("r5_late_ack_req", 32'(mem_req), 32'd0);
    chk("r5_late_ack_stall", 32'(core_stall), 32'd0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk("r5_idle_req", 32'(mem_req), 32'd0);
    do_load(32'h0000_0100, 1, -1, 1'b0);

    // Plan 6 and random mix: the CNT_W=2 twin must hold at 3.
    for (int k = 0; k < 4; k++) do_load(32'h0001_0000 + 32'(k << 8), 0, -1, 1'b0);
    chk("p6_sat_miss", 32'(mc2), 32'd3);

    for (int n = 0; n < 80; n++) begin
      int r, lat, fc;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      lat = $urandom_range(0, 3);
      fc = ($urandom_range(0, 5) == 0) ? $urandom_range(0, lat) : -1;
      a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      if (r <= 5)      do_load(a, lat, fc, r == 5);
      else if (r <= 7) do_store(a, $urandom, 1'b0, lat, fc);
      else if (r == 8) do_store(a, $urandom, 1'b1, lat, fc);
      else             do_flush();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
